// File: rtl/pport_phy.sv
// Pin-level link layer for the 7-bit parallel port: toggle req/ack pins on one side,
// single-cycle strobe/busy stream to the wishbone parallel-port core on the other.
module pport_phy #(
    parameter int NSYNC     = 2,
    parameter int SETUP_CYC = 2,
    parameter int LGTIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_pin_rxreq,
    input  logic [6:0] i_pin_rxdata,
    output logic       o_pin_rxack,
    output logic       o_rx_stb,
    output logic [6:0] o_rx_data,
    input  logic       i_tx_stb,
    input  logic [6:0] i_tx_data,
    output logic       o_tx_busy,
    output logic       o_pin_txreq,
    output logic [6:0] o_pin_txdata,
    input  logic       i_pin_txack,
    input  logic       i_clr_err,
    output logic       o_tx_timeout
);

    localparam int CNTW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam logic [LGTIMEOUT-1:0] WAIT_MAX = '1;
    localparam logic [LGTIMEOUT-1:0] WAIT_PRE = WAIT_MAX - 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } tx_state_t;

    logic [NSYNC-1:0] rq_sync_reg;
    logic [NSYNC-1:0] ak_sync_reg;
    logic             rq_s;
    logic             ak_s;
    logic             rq_d_reg;
    logic             rx_edge;

    tx_state_t            state_reg, state_next;
    logic [CNTW-1:0]      cnt_reg, cnt_next;
    logic [LGTIMEOUT-1:0] wait_reg, wait_next;
    logic                 txreq_reg, txreq_next;
    logic [6:0]           txdata_reg, txdata_next;
    logic                 timeout_reg, timeout_next;
    logic                 timeout_set;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rq_sync_reg <= '0;
            ak_sync_reg <= '0;
        end else begin
            rq_sync_reg <= {rq_sync_reg[NSYNC-2:0], i_pin_rxreq};
            ak_sync_reg <= {ak_sync_reg[NSYNC-2:0], i_pin_txack};
        end
    end

    assign rq_s    = rq_sync_reg[NSYNC-1];
    assign ak_s    = ak_sync_reg[NSYNC-1];
    assign rx_edge = rq_s ^ rq_d_reg;

    // Host keeps rxdata stable until it sees the ack, so capture on the edge cycle is safe.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rq_d_reg    <= 1'b0;
            o_rx_stb    <= 1'b0;
            o_rx_data   <= '0;
            o_pin_rxack <= 1'b0;
        end else begin
            rq_d_reg <= rq_s;
            o_rx_stb <= rx_edge;
            if (rx_edge) begin
                o_rx_data   <= i_pin_rxdata;
                o_pin_rxack <= rq_s;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            wait_reg    <= '0;
            txreq_reg   <= 1'b0;
            txdata_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            wait_reg    <= wait_next;
            txreq_reg   <= txreq_next;
            txdata_reg  <= txdata_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        wait_next   = wait_reg;
        txreq_next  = txreq_reg;
        txdata_next = txdata_reg;
        timeout_set = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_tx_stb) begin
                    txdata_next = i_tx_data;
                    cnt_next    = CNTW'(SETUP_CYC - 1);
                    state_next  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_reg == '0) begin
                    txreq_next = ~txreq_reg;
                    wait_next  = '0;
                    state_next = ST_WAIT;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_WAIT: begin
                // The request is never retracted: a late ack still completes the word.
                if (ak_s == txreq_reg) begin
                    state_next = ST_IDLE;
                end else if (wait_reg != WAIT_MAX) begin
                    wait_next   = wait_reg + 1'b1;
                    timeout_set = (wait_reg == WAIT_PRE);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        timeout_next = timeout_set | (timeout_reg & ~i_clr_err);
    end

    assign o_tx_busy    = (state_reg != ST_IDLE);
    assign o_pin_txreq  = txreq_reg;
    assign o_pin_txdata = txdata_reg;
    assign o_tx_timeout = timeout_reg;

endmodule
